mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Parametrised multiply/divide unit for the pipelined MIPS core. Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- Sits beside the EX stage. The hazard unit holds the pipeline while `busy` is high, and MFHI/MFLO read `hi`/`lo` directly.
- Multiplies use a fixed-latency pipeline. Divides use a radix-2 restoring iterative datapath with a sign-fixup cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥4).
- MUL_LATENCY, 4, cycles from start acceptance to `done` for multiplies (≥1).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when `busy`=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are ignored (no effect).
- a  in  WIDTH  rs operand (dividend / multiplicand / MTxx source).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort the in-flight operation (branch/jump flush).
- busy  out  1  operation in flight; start is not accepted.
- done  out  1  one-cycle pulse; `hi`/`lo` updated this cycle.
- div_by_zero  out  1  one-cycle pulse coincident with `done` for DIV/DIVU with `b`=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (Rst=0 at an edge):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0.
  - Any in-flight operation is discarded. Reset overrides every other input.
- States and transitions:
  - IDLE → MUL (MULT/MULTU accepted) or DIV (DIV/DIVU accepted with b≠0).
  - DIV → FIX after WIDTH iterations.
  - MUL → IDLE and FIX → IDLE when the result is written.
  - Divide by zero completes directly from IDLE.
- Timing convention: start is accepted at edge 0, i.e. `start`=1, `busy`=0, `flush`=0, and `op` valid in cycle 0.
- MULT/MULTU:
  - `busy`=1 in cycles 1..MUL_LATENCY-1.
  - `done`=1, `busy`=0 and new hi/lo visible in cycle MUL_LATENCY.
  - {hi,lo} = full 2·WIDTH-bit product, signed for MULT and unsigned for MULTU.
  - For MUL_LATENCY=1, `busy` is never asserted.
- DIV/DIVU (b≠0):
  - WIDTH iteration cycles plus 1 fixup cycle.
  - `busy`=1 in cycles 1..WIDTH+1; `done` in cycle WIDTH+2.
  - DIVU: lo = a/b, hi = a mod b, both unsigned.
  - DIV: iterate on magnitudes.
    - Quotient is negated if sign(a)≠sign(b).
    - Remainder takes the sign of a (truncating division).
  - Overflow case MIN/−1: lo=MIN, hi=0, no error flag.
- DIV/DIVU with b=0:
  - `done`=1 and `div_by_zero`=1 in cycle 1; `busy` never asserted.
  - hi=a, lo=all ones.
- MTHI/MTLO:
  - hi (or lo) ← a at edge 0, visible in cycle 1.
  - No `busy`, no `done`.
- Operands: a, b and the signed/unsigned mode are captured at acceptance. Input changes while `busy`=1 have no effect.
- `start` while `busy`=1 is ignored; no queueing.
- Back-to-back operation: `start` in the `done` cycle (busy=0) is accepted.
- flush:
  - Flush at any edge with state≠IDLE: return to IDLE at that edge. `busy`=0 next cycle; no `done`; hi/lo unchanged.
  - Flush and start in the same cycle: flush wins and the start is dropped, including MTHI/MTLO.
  - Flush in the `done` cycle: no effect, since the result is already committed.
- Arithmetic:
  - Internal product is 2·WIDTH bits.
  - Partial remainder is WIDTH+1 bits.
  - Negation is two's complement modulo 2^WIDTH.

Test Plan (WIDTH=32, MUL_LATENCY=4):
- MULT a=0xFFFFFFFD (−3), b=5 → busy cycles 1–3; done in cycle 4; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF → done in cycle 4; hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands issued in the done cycle → done 4 cycles later; hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → busy cycles 1–33; done in cycle 34; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → done=div_by_zero=1 in cycle 1; hi=0x00000064, lo=0xFFFFFFFF; busy stays 0.
- Preload with MTHI 0x1234 and MTLO 0x5678, then DIVU 50/7. Pulse start with MULT in cycle 5 → ignored. Flush in cycle 10 → busy=0 from cycle 11; no done ever; hi=0x1234, lo=0x5678.
- MULTU in flight, Rst=0 in cycle 2 → cycle 3: busy=0, hi=lo=0, no done. Flush+start(MTLO a=9) in the same cycle → lo unchanged.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Fixed-latency multiply, radix-2 restoring divide with a sign-fixup cycle.
module mips_muldiv_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH + MUL_LATENCY) + 1;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dbz_q, dbz_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quot_q, quot_d;
    logic [WIDTH-1:0]     dvsr_q, dvsr_d;
    logic                 negq_q, negq_d;
    logic                 negr_q, negr_d;

    logic                 accept;
    logic                 is_signed;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_trial;

    assign accept    = start && !flush && (state_q == StIdle);
    assign is_signed = (op == OpMult) || (op == OpDiv);
    assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

    // Sign- or zero-extend to the full product width so one multiplier serves both modes.
    assign a_ext    = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext    = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign mul_prod = a_ext * b_ext;

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, dvsr_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (op)
                        OpMult, OpMultu: begin
                            if (MUL_LATENCY == 1) begin
                                {hi_d, lo_d} = mul_prod;
                                done_d       = 1'b1;
                            end else begin
                                prod_d  = mul_prod;
                                cnt_d   = CntW'(MUL_LATENCY - 2);
                                state_d = StMul;
                            end
                        end
                        OpDiv, OpDivu: begin
                            if (b == '0) begin
                                hi_d   = a;
                                lo_d   = '1;
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                rem_d   = '0;
                                quot_d  = a_mag;
                                dvsr_d  = b_mag;
                                negq_d  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                                negr_d  = is_signed && a[WIDTH-1];
                                cnt_d   = CntW'(WIDTH - 1);
                                state_d = StDiv;
                            end
                        end
                        OpMthi:  hi_d = a;
                        OpMtlo:  lo_d = a;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (cnt_q == '0) begin
                    {hi_d, lo_d} = prod_q;
                    done_d       = 1'b1;
                    state_d      = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDiv: begin
                if (!rem_trial[WIDTH]) begin
                    rem_d  = rem_trial[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StFix: begin
                lo_d    = negq_q ? -quot_q : quot_q;
                hi_d    = negr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        // An abort discards whatever the in-flight operation would have committed.
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            prod_q  <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvsr_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed plus randomized bench for mips_muldiv_unit against a plain-arithmetic reference model.
module tb_mips_muldiv_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
    logic        exp_dz;

    mips_muldiv_unit #(.WIDTH(32), .MUL_LATENCY(4)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: results from ordinary integer arithmetic, latency from the timing rules.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, sq, sr;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        exp_hi = mdl_hi; exp_lo = mdl_lo; exp_lat = 0; exp_dz = 1'b0;
        case (o)
            3'd0: begin p = 64'(sx * sy); {exp_hi, exp_lo} = p; exp_lat = 4; end
            3'd1: begin p = {32'd0, x} * {32'd0, y}; {exp_hi, exp_lo} = p; exp_lat = 4; end
            3'd2, 3'd3: begin
                if (y == 0) begin
                    exp_hi = x; exp_lo = 32'hFFFF_FFFF; exp_lat = 1; exp_dz = 1'b1;
                end else if (o == 3'd2) begin
                    sq = sx / sy; sr = sx % sy;
                    exp_lo = sq[31:0]; exp_hi = sr[31:0]; exp_lat = 34;
                end else begin
                    exp_lo = x / y; exp_hi = x % y; exp_lat = 34;
                end
            end
            3'd4:    exp_hi = x;
            3'd5:    exp_lo = x;
            default: ;
        endcase
    endtask

    task automatic wait_done(input string tag);
        int cyc;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            chk({tag, " busy"}, 64'(busy), 64'd1);
            step();
            cyc++;
        end
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, " busy@done"}, 64'(busy), 64'd0);
        chk({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dz));
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
        mdl_hi = exp_hi;
        mdl_lo = exp_lo;
    endtask

    // Accepts at the next edge; returns in cycle 1 (or in the done cycle when wait_it is set).
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input string tag, input bit wait_it);
        model(o, x, y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        if (exp_lat == 0) begin
            chk({tag, " busy"}, 64'(busy), 64'd0);
            chk({tag, " done"}, 64'(done), 64'd0);
            chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
            chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
            mdl_hi = exp_hi;
            mdl_lo = exp_lo;
        end else if (wait_it) begin
            wait_done(tag);
        end
    endtask

    task automatic idle_no_done(input string tag, input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
            step();
        end
        chk({tag, " quiet"}, 64'(seen), 64'd0);
        chk({tag, " hi"}, 64'(hi), 64'(mdl_hi));
        chk({tag, " lo"}, 64'(lo), 64'(mdl_lo));
    endtask

    initial begin
        logic [31:0] rx, ry;
        logic [2:0]  ro;
        Rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        step(); step();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        Rst = 1'b1;
        step();

        issue(3'd0, 32'hFFFF_FFFD, 32'd5, "mult -3*5", 1'b1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", 1'b1);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult b2b", 1'b1);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2", 1'b1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1", 1'b1);
        issue(3'd3, 32'd100, 32'd0, "divu by 0", 1'b1);
        step();
        chk("dbz pulse", 64'(div_by_zero), 64'd0);
        issue(3'd6, 32'hDEAD_BEEF, 32'd1, "op6 ignored", 1'b0);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1, "op7 ignored", 1'b0);

        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       ry = 32'd0;
                1:       ry = $urandom_range(1, 9);
                2:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            for (int k = $urandom_range(0, 2); k > 0; k--) step();
            issue(ro, rx, ry, $sformatf("rand%0d op%0d", i, ro), 1'b1);
        end

        // Divide aborted mid-flight; a start while busy must be dropped.
        issue(3'd4, 32'h1234, 32'd0, "mthi", 1'b0);
        issue(3'd5, 32'h5678, 32'd0, "mtlo", 1'b0);
        issue(3'd3, 32'd50, 32'd7, "divu flushed", 1'b0);
        for (int c = 1; c < 5; c++) step();
        start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3;
        step();
        start = 1'b0;
        chk("start while busy", 64'(busy), 64'd1);
        for (int c = 6; c < 10; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("div flush busy", 64'(busy), 64'd0);
        idle_no_done("div flush", 45);

        issue(3'd0, 32'd7, 32'd9, "mult flushed", 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mult flush busy", 64'(busy), 64'd0);
        idle_no_done("mult flush", 8);

        // Flush in the done cycle cannot undo a committed result.
        issue(3'd1, 32'd11, 32'd13, "multu pre-flush", 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush@done hi", 64'(hi), 64'd0);
        chk("flush@done lo", 64'(lo), 64'd143);

        issue(3'd1, 32'hFFFF_FFFF, 32'd3, "multu reset", 1'b0);
        step();
        Rst = 1'b0;
        step();
        Rst = 1'b1;
        mdl_hi = '0; mdl_lo = '0;
        chk("reset mid busy", 64'(busy), 64'd0);
        chk("reset mid hi", 64'(hi), 64'd0);
        chk("reset mid lo", 64'(lo), 64'd0);
        idle_no_done("after reset", 6);

        issue(3'd5, 32'h77, 32'd0, "mtlo preload", 1'b0);
        start = 1'b1; flush = 1'b1; op = 3'd5; a = 32'd9;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush+mtlo lo", 64'(lo), 64'h77);
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd2; b = 32'd2;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush+mult busy", 64'(busy), 64'd0);
        idle_no_done("flush+start", 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
